// File: rtl/instr_fetch_unit.sv
// PC/fetch sequencer with MIPS branch-delay-slot handling and halt-on-address.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault output.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_in,
  output logic [31:0] instr,
  output logic [31:0] link_addr,
  output logic        active,
  output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [1:0] {StRun, StDelay, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_inc;
  logic        issue;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  if (RESET_VECTOR[1:0] != 2'b00) begin : g_bad_reset_vector
    $error("instr_fetch_unit: RESET_VECTOR must be word aligned");
  end
`endif

  assign pc_inc = pc_q + 32'd4;
  assign issue  = (state_q != StHalted) && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    count_d = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    if (issue) begin
      count_d = count_q + 32'd1;
      unique case (state_q)
        StRun: begin
          pc_d = pc_inc;
          if (pc_inc == HALT_ADDR) begin
            state_d = StHalted;
          end else if (branch_taken) begin
`ifdef FETCH_ALIGN_CHECK_EN
            pend_d = branch_target;
`else
            pend_d = branch_target & 32'hFFFF_FFFC;
`endif
            state_d = StDelay;
          end
        end
        StDelay: begin
          // Redirects arriving from the delay slot are dropped; the first one wins.
`ifdef FETCH_ALIGN_CHECK_EN
          if (pend_q[1:0] != 2'b00) begin
            pc_d    = HALT_ADDR;
            state_d = StHalted;
            fault_d = 1'b1;
          end else
`endif
          begin
            pc_d    = pend_q;
            state_d = (pend_q == HALT_ADDR) ? StHalted : StRun;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
      count_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      count_q <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign active        = (state_q != StHalted);
  assign instr_address = pc_q;
  assign instr         = active ? instr_in : 32'h0;
  assign link_addr     = pc_q + 32'd8;
  assign fetch_count   = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit (default build): each row gives the inputs for one
// cycle and the outputs expected before that cycle's rising edge.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr_address;
  logic [31:0] instr_in;
  logic [31:0] instr;
  logic [31:0] link_addr;
  logic        active;
  logic [31:0] fetch_count;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr_address (instr_address),
    .instr_in      (instr_in),
    .instr         (instr),
    .link_addr     (link_addr),
    .active        (active),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        act;
    logic [31:0] cnt;
  } vec_t;

  localparam int NumVec = 23;
  vec_t vec [NumVec];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic do_row(input int idx, input vec_t v);
    logic [31:0] word;
    string       tag;
    @(negedge clk);
    word          = 32'hA500_0000 ^ idx;
    rst_n         = v.rst_n;
    stall         = v.stall;
    branch_taken  = v.br;
    branch_target = v.tgt;
    instr_in      = word;
    #1;
    tag = $sformatf("row%0d", idx);
    check({tag, ".instr_address"}, instr_address, v.pc);
    check({tag, ".link_addr"}, link_addr, v.pc + 32'd8);
    check({tag, ".active"}, {31'h0, active}, {31'h0, v.act});
    check({tag, ".fetch_count"}, fetch_count, v.cnt);
    check({tag, ".instr"}, instr, v.act ? word : 32'h0);
  endtask

  initial begin
    //           rst  stl  br   target          pc              act  count
    vec[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 32'd0};
    vec[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00004, 1'b1, 32'd1};
    vec[2]  = '{1'b1, 1'b0, 1'b1, 32'hBFC00040, 32'hBFC00008, 1'b1, 32'd2};
    vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC0000C, 1'b1, 32'd3};
    vec[4]  = '{1'b1, 1'b0, 1'b1, 32'hBFC00100, 32'hBFC00040, 1'b1, 32'd4};
    vec[5]  = '{1'b1, 1'b1, 1'b1, 32'h12345678, 32'hBFC00044, 1'b1, 32'd5};
    vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,        32'hBFC00044, 1'b1, 32'd5};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 32'h0,        32'hBFC00044, 1'b1, 32'd5};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 32'hBFC00200, 32'hBFC00044, 1'b1, 32'd5};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 32'hBFC00300, 32'hBFC00100, 1'b1, 32'd6};
    vec[10] = '{1'b0, 1'b0, 1'b1, 32'hBFC00400, 32'hBFC00104, 1'b1, 32'd7};
    vec[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 32'd0};
    vec[12] = '{1'b1, 1'b0, 1'b1, 32'hBFC00042, 32'hBFC00004, 1'b1, 32'd1};
    vec[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00008, 1'b1, 32'd2};
    vec[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00040, 1'b1, 32'd3};
    vec[15] = '{1'b1, 1'b1, 1'b1, 32'hBFC00800, 32'hBFC00044, 1'b1, 32'd4};
    vec[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00044, 1'b1, 32'd4};
    vec[17] = '{1'b1, 1'b0, 1'b1, 32'h0,        32'hBFC00048, 1'b1, 32'd5};
    vec[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC0004C, 1'b1, 32'd6};
    vec[19] = '{1'b1, 1'b0, 1'b1, 32'hBFC00000, 32'h00000000, 1'b0, 32'd7};
    vec[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000000, 1'b0, 32'd7};
    vec[21] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0, 32'd7};
    vec[22] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00000, 1'b1, 32'd0};

    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    instr_in      = 32'h0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NumVec; i++) do_row(i, vec[i]);

    // Sequential wrap past 32'hFFFFFFFC lands on HALT_ADDR and halts.
    do_row(100, '{1'b1, 1'b0, 1'b1, 32'hFFFFFFF8, 32'hBFC00004, 1'b1, 32'd1});
    do_row(101, '{1'b1, 1'b0, 1'b0, 32'h0,        32'hBFC00008, 1'b1, 32'd2});
    do_row(102, '{1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFF8, 1'b1, 32'd3});
    do_row(103, '{1'b1, 1'b0, 1'b0, 32'h0,        32'hFFFFFFFC, 1'b1, 32'd4});
    do_row(104, '{1'b1, 1'b0, 1'b1, 32'hBFC00000, 32'h00000000, 1'b0, 32'd5});
    do_row(105, '{1'b1, 1'b0, 1'b0, 32'h0,        32'h00000000, 1'b0, 32'd5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
